// File: rtl/sp_async_read_mem_if.sv
// Bus bundle for the single-port async-read memory: one shared address, a write
// port and a combinational read data return.
interface sp_async_read_mem_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_enb;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output addr,
        output wr_enb,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  addr,
        input  wr_enb,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/sp_async_read_mem.sv
// Single-port flop-array RAM: synchronous write, combinational read of mem[addr],
// whole array cleared by an asynchronous active-low reset.
module sp_async_read_mem #(
    parameter int unsigned          DATA_WIDTH  = 8,
    parameter int unsigned          ADDR_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sp_async_read_mem_if.slave       bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Only the addressed word takes the new value; all others hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.wr_enb) begin
            mem_d[bus.addr] = bus.wr_data;
        end
    end

    // Reset branch also fires on clock edges while rst_n is low, so writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // No bypass: before a write edge the old contents are visible.
    assign bus.rd_data = mem_q[bus.addr];
endmodule

// File: tb/tb_sp_async_read_mem.sv
// Directed bench for sp_async_read_mem: reset clear, write/read, read-after-write,
// write-enable gating and asynchronous reset in the middle of operation.
module tb_sp_async_read_mem;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    sp_async_read_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sp_async_read_mem #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, commit on the following rising edge.
    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = d;
        bus.wr_enb  = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_enb  = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        bus.addr = a;
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        logic [DW-1:0] d;
        n_vec       = 0;
        n_bad       = 0;
        rst_n       = 1'b1;
        bus.addr    = '0;
        bus.wr_enb  = 1'b0;
        bus.wr_data = '0;

        // Reset pulse, then sweep
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            read_word("reset_sweep", AW'(i), 8'h00);
        end

        // Basic write/read
        write_word(4'd3, 8'hAB);
        read_word("basic_a3", 4'd3, 8'hAB);
        read_word("basic_a4", 4'd4, 8'h00);

        // Distinct pattern, read back in reverse
        for (int i = 0; i < 16; i++) begin
            write_word(AW'(i), 8'(i) ^ 8'h5A);
        end
        for (int i = 15; i >= 0; i--) begin
            d = 8'(i) ^ 8'h5A;
            read_word("pattern", AW'(i), d);
        end
        read_word("pattern_a0", 4'd0, 8'h5A);
        read_word("pattern_a15", 4'd15, 8'h55);

        // Read immediately around a write edge
        write_word(4'd7, 8'h11);
        @(negedge clk);
        bus.addr    = 4'd7;
        bus.wr_data = 8'hC3;
        bus.wr_enb  = 1'b1;
        #4;
        check("rdw_before_edge", bus.rd_data, 8'h11);
        @(posedge clk);
        #1;
        check("rdw_after_edge", bus.rd_data, 8'hC3);
        bus.wr_enb = 1'b0;

        // Write-enable gating
        write_word(4'd9, 8'h22);
        @(negedge clk);
        bus.addr    = 4'd9;
        bus.wr_data = 8'hFF;
        bus.wr_enb  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("wr_gated", bus.rd_data, 8'h22);
        end

        // Fill, then asynchronous reset between edges
        for (int i = 0; i < 16; i++) begin
            write_word(AW'(i), 8'(i + 8'h81));
        end
        read_word("fill_a3", 4'd3, 8'h84);
        @(negedge clk);
        bus.addr = 4'd3;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a3", bus.rd_data, 8'h00);
        bus.addr = 4'd12;
        #1;
        check("async_rst_a12", bus.rd_data, 8'h00);
        bus.addr    = 4'd3;
        bus.wr_data = 8'h77;
        bus.wr_enb  = 1'b1;
        @(posedge clk);
        #1;
        check("wr_in_reset", bus.rd_data, 8'h00);
        @(negedge clk);
        bus.wr_enb = 1'b0;
        rst_n      = 1'b1;
        read_word("post_rst_a3", 4'd3, 8'h00);

        // First write after release is accepted
        write_word(4'd5, 8'h3C);
        read_word("post_rst_wr", 4'd5, 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
